// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: captures an accumulator tile, then streams
// requantized rows (round-half-up shift plus saturation) over valid/ready.

module systolic_result_drain_lane #(
  parameter int ACCUM_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [ACCUM_WIDTH-1:0] x,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   col_en,
  output logic [OUT_WIDTH-1:0]   y,
  output logic                   sat
);
  localparam logic signed [ACCUM_WIDTH:0] ONE  = {{ACCUM_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [ACCUM_WIDTH:0] MAXV = {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH:0] MINV = {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACCUM_WIDTH:0] xe, rnd, sum, sh;

  // One extra bit of headroom so the rounding add never wraps.
  always_comb begin
    xe  = {x[ACCUM_WIDTH-1], x};
    rnd = (shift == '0) ? '0 : (ONE << (shift - 1'b1));
    sum = xe + rnd;
    sh  = sum >>> shift;
    y   = '0;
    sat = 1'b0;
    if (col_en) begin
      if (sh > MAXV) begin
        y   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        sat = 1'b1;
      end else if (sh < MINV) begin
        y   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        sat = 1'b1;
      end else begin
        y = sh[OUT_WIDTH-1:0];
      end
    end
  end
endmodule

module systolic_result_drain #(
  parameter int ARRAY_SIZE  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         result_valid,
  input  logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
  input  logic [$clog2(ARRAY_SIZE+1)-1:0]              cfg_rows,
  input  logic [$clog2(ARRAY_SIZE+1)-1:0]              cfg_cols,
  input  logic [SHIFT_WIDTH-1:0]                       cfg_shift,
  output logic                                         capture_ready,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [OUT_WIDTH*ARRAY_SIZE-1:0]              out_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]                out_row_idx,
  output logic [ARRAY_SIZE-1:0]                        out_col_mask,
  output logic                                         out_last,
  output logic                                         drain_done,
  output logic                                         sat_flag,
  output logic                                         drop_err
);
  localparam int CW = $clog2(ARRAY_SIZE+1);
  localparam int IW = $clog2(ARRAY_SIZE);
  localparam logic [CW-1:0] FULL = CW'(ARRAY_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [CW-1:0]          rows;
    logic [CW-1:0]          cols;
    logic [SHIFT_WIDTH-1:0] shift;
  } cfg_t;

  state_t state_q, state_d;
  cfg_t   cfg_q, cfg_in;
  logic   capture, load_row, finish, hs;

  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][ACCUM_WIDTH-1:0] tile_q;
  logic [ARRAY_SIZE-1:0][OUT_WIDTH-1:0]                   lane_y;
  logic [ARRAY_SIZE-1:0]                                  lane_sat;
  logic [ARRAY_SIZE-1:0]                                  col_en;
  logic [IW-1:0]                                          row_sel;
  logic                                                   row_last;

  assign hs            = out_valid && out_ready;
  assign capture_ready = (state_q == IDLE);
  assign drain_done    = (state_q == DONE);

  // Zero or oversized dimensions mean a full tile.
  always_comb begin
    cfg_in.rows  = (cfg_rows == '0 || cfg_rows > FULL) ? FULL : cfg_rows;
    cfg_in.cols  = (cfg_cols == '0 || cfg_cols > FULL) ? FULL : cfg_cols;
    cfg_in.shift = cfg_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load_row = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: if (result_valid) begin
        capture = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        load_row = 1'b1;
        state_d  = DRAIN;
      end
      DRAIN: if (hs) begin
        if (out_last) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          load_row = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LOAD fetches row 0; each non-last handshake prefetches the following row.
  assign row_sel  = (state_q == LOAD) ? '0 : out_row_idx + 1'b1;
  assign row_last = (CW'(row_sel) == cfg_q.rows - 1'b1);

  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
    assign col_en[c] = (CW'(c) < cfg_q.cols);
    systolic_result_drain_lane #(
      .ACCUM_WIDTH(ACCUM_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .x     (tile_q[row_sel][c]),
      .shift (cfg_q.shift),
      .col_en(col_en[c]),
      .y     (lane_y[c]),
      .sat   (lane_sat[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_q       <= '0;
      cfg_q        <= '0;
      out_valid    <= 1'b0;
      out_row      <= '0;
      out_row_idx  <= '0;
      out_col_mask <= '0;
      out_last     <= 1'b0;
      sat_flag     <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      drop_err <= result_valid && (state_q != IDLE);
      if (capture) begin
        tile_q   <= result_flat;
        cfg_q    <= cfg_in;
        sat_flag <= 1'b0;
      end
      if (load_row) begin
        out_valid    <= 1'b1;
        out_row      <= lane_y;
        out_row_idx  <= row_sel;
        out_col_mask <= col_en;
        out_last     <= row_last;
        sat_flag     <= sat_flag | (|lane_sat);
      end
      if (finish) out_valid <= 1'b0;
    end
  end
endmodule
